// File: rtl/coprocessor_sequencer_if.sv
// Control handshake between the coprocessor sequencer and the datapath
// blocks (image_processing, RAMProc, zoom_controller, vga_controller).
interface coprocessor_sequencer_if;
  logic [1:0] ALGORITHM;
  logic       PROC_START;
  logic       PROC_DONE;
  logic       RAM_WREN;
  logic       ZOOM_REQUESTED;
  logic       FRAME_VALID;
  logic       BUSY;
  logic       ERROR;

  modport master (
    output ALGORITHM, PROC_START, RAM_WREN, ZOOM_REQUESTED, FRAME_VALID, BUSY, ERROR,
    input  PROC_DONE
  );

  modport slave (
    input  ALGORITHM, PROC_START, RAM_WREN, ZOOM_REQUESTED, FRAME_VALID, BUSY, ERROR,
    output PROC_DONE
  );
endinterface

// File: rtl/coprocessor_sequencer.sv
// Coprocessor control FSM: debounced RUN/SELECT buttons, one processing pass,
// write-enable gating and frame display. Optional watchdog: COPROCESSOR_SEQUENCER_WATCHDOG_EN.
module coprocessor_sequencer_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          deb;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync  <= 2'b11;
      deb   <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // deb==1 here means a 1->0 transition, i.e. a press
        deb   <= sync[1];
        cnt   <= '0;
        press <= deb;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module coprocessor_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FLUSH_CYCLES    = 4,
  parameter int WATCHDOG_CYCLES = 2000000
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    RUN,
  input  logic                    ALGORITHM_SELECTOR,
  coprocessor_sequencer_if.master bus
);
  localparam int NUM_BTN = 2;
  localparam int FW      = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ARM, RUNNING, FLUSH, SHOW, ERROR_HALT} state_t;

  typedef struct packed {
    logic start;
    logic wren;
    logic zoom;
    logic fv;
    logic busy;
    logic err;
  } seq_out_t;

  logic [NUM_BTN-1:0] btn_raw, press;
  logic               run_ev, sel_ev;

  assign btn_raw = {ALGORITHM_SELECTOR, RUN};
  assign run_ev  = press[0];
  assign sel_ev  = press[1];

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    coprocessor_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .CLK   (CLK),
      .RESET (RESET),
      .btn   (btn_raw[i]),
      .press (press[i])
    );
  end

  state_t        state, state_n;
  logic [1:0]    algo, algo_n;
  logic [FW-1:0] fcnt, fcnt_n;
  seq_out_t      out_q, out_n;

`ifdef COPROCESSOR_SEQUENCER_WATCHDOG_EN
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
  logic [WW-1:0] wdog;

  // Cleared whenever not running, so it starts at 0 on every RUNNING entry
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                 wdog <= '0;
    else if (state != RUNNING)  wdog <= '0;
    else                        wdog <= wdog + 1'b1;
  end
`endif

  always_comb begin
    state_n = state;
    algo_n  = algo;
    fcnt_n  = fcnt;
    case (state)
      IDLE: begin
        if (sel_ev)      algo_n  = algo + 2'd1;
        else if (run_ev) state_n = ARM;
      end
      ARM: state_n = RUNNING;
      RUNNING: begin
        if (bus.PROC_DONE) begin
          state_n = FLUSH;
          fcnt_n  = '0;
        end
`ifdef COPROCESSOR_SEQUENCER_WATCHDOG_EN
        else if (wdog == WW'(WATCHDOG_CYCLES - 1)) state_n = ERROR_HALT;
`endif
      end
      FLUSH: begin
        if (fcnt == FW'(FLUSH_CYCLES - 1)) state_n = SHOW;
        else                               fcnt_n  = fcnt + 1'b1;
      end
      SHOW: begin
        if (sel_ev) begin
          algo_n  = algo + 2'd1;
          state_n = IDLE;
        end else if (run_ev) begin
          state_n = ARM;
        end
      end
      ERROR_HALT: if (run_ev) state_n = IDLE;
      default:    state_n = IDLE;
    endcase

    // Outputs are a registered decode of the next state
    out_n = '0;
    case (state_n)
      ARM: begin
        out_n.start = 1'b1;
        out_n.wren  = 1'b1;
        out_n.busy  = 1'b1;
      end
      RUNNING, FLUSH: begin
        out_n.wren = 1'b1;
        out_n.busy = 1'b1;
      end
      SHOW: begin
        out_n.fv   = 1'b1;
        out_n.zoom = 1'b1;
      end
`ifdef COPROCESSOR_SEQUENCER_WATCHDOG_EN
      ERROR_HALT: out_n.err = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      algo  <= 2'd0;
      fcnt  <= '0;
      out_q <= '0;
    end else begin
      state <= state_n;
      algo  <= algo_n;
      fcnt  <= fcnt_n;
      out_q <= out_n;
    end
  end

  assign bus.ALGORITHM      = algo;
  assign bus.PROC_START     = out_q.start;
  assign bus.RAM_WREN       = out_q.wren;
  assign bus.ZOOM_REQUESTED = out_q.zoom;
  assign bus.FRAME_VALID    = out_q.fv;
  assign bus.BUSY           = out_q.busy;
  assign bus.ERROR          = out_q.err;
endmodule

// File: tb/tb_coprocessor_sequencer.sv
// Directed bench for coprocessor_sequencer: debounce, pass sequencing,
// algorithm select, async reset and (macro-dependent) watchdog.
module tb_coprocessor_sequencer;
  localparam int DEB = 4;
  localparam int FL  = 2;
  localparam int WD  = 50;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  logic RUN   = 1'b1;
  logic SEL   = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  coprocessor_sequencer_if bus();

  coprocessor_sequencer #(
    .DEBOUNCE_CYCLES (DEB),
    .FLUSH_CYCLES    (FL),
    .WATCHDOG_CYCLES (WD)
  ) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .RUN                (RUN),
    .ALGORITHM_SELECTOR (SEL),
    .bus                (bus.master)
  );

  always #5 CLK = ~CLK;

  // {alg[1:0], start, wren, zoom, fv, busy, err}
  // RUNNING=8'h12 ARM=8'h32 SHOW=8'h0C ERROR_HALT=8'h01 (plus alg<<6)
  logic [7:0] outs;
  assign outs = {bus.ALGORITHM, bus.PROC_START, bus.RAM_WREN, bus.ZOOM_REQUESTED,
                 bus.FRAME_VALID, bus.BUSY, bus.ERROR};

  // Hold selected buttons low for 'hold' cycles, release, let release settle
  task automatic press(input logic r, input logic s, input int hold, output int starts);
    starts = 0;
    RUN = r ? 1'b0 : 1'b1;
    SEL = s ? 1'b0 : 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      if (bus.PROC_START === 1'b1) starts++;
    end
    RUN = 1'b1;
    SEL = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (bus.PROC_START === 1'b1) starts++;
    end
  endtask

  task automatic pulse_done();
    bus.PROC_DONE = 1'b1;
    @(negedge CLK);
    bus.PROC_DONE = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    bus.PROC_DONE = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (outs !== 8'h00) begin n_bad++; $display("FAIL reset_outs: got %h want 00", outs); end
    RESET = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (outs !== 8'h00) begin n_bad++; $display("FAIL idle_quiet[%0d]: got %h want 00", i, outs); end
    end
  endtask

  task automatic test_debounce();
    int st;
    press(1'b1, 1'b0, 3, st);
    n_cmp++;
    if (st !== 0) begin n_bad++; $display("FAIL glitch_start: got %0d want 0", st); end
    n_cmp++;
    if (outs !== 8'h00) begin n_bad++; $display("FAIL glitch_outs: got %h want 00", outs); end
    press(1'b1, 1'b0, 10, st);
    n_cmp++;
    if (st !== 1) begin n_bad++; $display("FAIL press_start_count: got %0d want 1", st); end
    n_cmp++;
    if (outs !== 8'h12) begin n_bad++; $display("FAIL running_outs: got %h want 12", outs); end
  endtask

  task automatic test_full_pass();
    bus.PROC_DONE = 1'b1;
    @(negedge CLK);
    bus.PROC_DONE = 1'b0;
    n_cmp++;
    if (outs !== 8'h12) begin n_bad++; $display("FAIL flush_d1: got %h want 12", outs); end
    @(negedge CLK);
    n_cmp++;
    if (outs !== 8'h12) begin n_bad++; $display("FAIL flush_d2: got %h want 12", outs); end
    @(negedge CLK);
    n_cmp++;
    if (outs !== 8'h0C) begin n_bad++; $display("FAIL show_d3: got %h want 0c", outs); end
    repeat (10) @(negedge CLK);
    n_cmp++;
    if (outs !== 8'h0C) begin n_bad++; $display("FAIL show_hold: got %h want 0c", outs); end
  endtask

  task automatic test_select();
    int st;
    int exp_alg[5] = '{2, 3, 0, 1, 2};
    press(1'b0, 1'b1, 10, st);
    n_cmp++;
    if (outs !== 8'h40 || st !== 0) begin
      n_bad++; $display("FAIL show_select: got %h/%0d want 40/0", outs, st);
    end
    for (int i = 0; i < 5; i++) begin
      press(1'b0, 1'b1, 10, st);
      n_cmp++;
      if (bus.ALGORITHM !== 2'(exp_alg[i])) begin
        n_bad++; $display("FAIL idle_select[%0d]: got %0d want %0d", i, bus.ALGORITHM, exp_alg[i]);
      end
    end
    press(1'b1, 1'b1, 10, st);
    n_cmp++;
    if (outs !== 8'hC0 || st !== 0) begin
      n_bad++; $display("FAIL idle_both: got %h/%0d want c0/0", outs, st);
    end
    press(1'b1, 1'b0, 10, st);
    n_cmp++;
    if (outs !== 8'hD2 || st !== 1) begin
      n_bad++; $display("FAIL run_alg3: got %h/%0d want d2/1", outs, st);
    end
    press(1'b0, 1'b1, 10, st);
    n_cmp++;
    if (outs !== 8'hD2) begin n_bad++; $display("FAIL select_in_run: got %h want d2", outs); end
    pulse_done();
    n_cmp++;
    if (outs !== 8'hCC) begin n_bad++; $display("FAIL show_alg3: got %h want cc", outs); end
    press(1'b1, 1'b1, 10, st);
    n_cmp++;
    if (outs !== 8'h00 || st !== 0) begin
      n_bad++; $display("FAIL show_both: got %h/%0d want 00/0", outs, st);
    end
    press(1'b1, 1'b0, 10, st);
    pulse_done();
    press(1'b1, 1'b0, 10, st);
    n_cmp++;
    if (outs !== 8'h12 || st !== 1) begin
      n_bad++; $display("FAIL show_rerun: got %h/%0d want 12/1", outs, st);
    end
    pulse_done();
  endtask

  task automatic test_midpass_reset();
    int st;
    press(1'b1, 1'b0, 10, st);
    RESET = 1'b0;
    #1;
    n_cmp++;
    if (outs !== 8'h00) begin n_bad++; $display("FAIL async_reset: got %h want 00", outs); end
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    press(1'b1, 1'b0, 10, st);
    n_cmp++;
    if (outs !== 8'h12 || st !== 1) begin
      n_bad++; $display("FAIL restart_after_reset: got %h/%0d want 12/1", outs, st);
    end
    pulse_done();
  endtask

  task automatic test_watchdog();
    int  st;
    bit  seen = 1'b0;
    RUN = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (bus.PROC_START === 1'b1) seen = 1'b1;
    end
    RUN = 1'b1;
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL wd_start: got no PROC_START want pulse within 20 cycles"); end
    if (seen) begin
      repeat (WD) @(negedge CLK);
      n_cmp++;
      if (outs !== 8'h12) begin n_bad++; $display("FAIL wd_last_run: got %h want 12", outs); end
      @(negedge CLK);
`ifdef COPROCESSOR_SEQUENCER_WATCHDOG_EN
      n_cmp++;
      if (outs !== 8'h01) begin n_bad++; $display("FAIL wd_halt: got %h want 01", outs); end
      press(1'b0, 1'b1, 10, st);
      n_cmp++;
      if (outs !== 8'h01) begin n_bad++; $display("FAIL wd_select_ignored: got %h want 01", outs); end
      press(1'b1, 1'b0, 10, st);
      n_cmp++;
      if (outs !== 8'h00 || st !== 0) begin
        n_bad++; $display("FAIL wd_clear: got %h/%0d want 00/0", outs, st);
      end
`else
      n_cmp++;
      if (outs !== 8'h12) begin n_bad++; $display("FAIL wd_absent: got %h want 12", outs); end
      repeat (10) @(negedge CLK);
      n_cmp++;
      if (outs !== 8'h12) begin n_bad++; $display("FAIL wd_absent_hold: got %h want 12", outs); end
      pulse_done();
      n_cmp++;
      if (outs !== 8'h0C) begin n_bad++; $display("FAIL wd_absent_show: got %h want 0c", outs); end
`endif
    end
  endtask

  initial begin
    bus.PROC_DONE = 1'b0;
    test_reset();
    test_debounce();
    test_full_pass();
    test_select();
    test_midpass_reset();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/coprocessor_sequencer.md
Name: coprocessor_sequencer

Overview:
Top-level control FSM for the coprocessor datapath. It debounces the RUN and ALGORITHM_SELECTOR pushbuttons and latches the algorithm choice. It sequences one image_processing pass, gating the RAMProc write enable during that pass, then asserts zoom_requested and frame-valid so vga_controller and zoom_controller show the result. It replaces the constant tie-offs on RAMProc wren, image_processing done and zoom_controller zoom_requested.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a synchronized button level is accepted (min 2)
FLUSH_CYCLES, 4, cycles RAM_WREN stays high after PROC_DONE so datapath pipeline writes drain (min 1)
WATCHDOG_CYCLES, 2000000, max cycles in RUNNING before abort (only with WATCHDOG_EN)

Ports:
CLK  in  1  system clock (same domain as image_processing and RAMProc)
RESET  in  1  asynchronous, active-low reset
RUN  in  1  raw pushbutton, asynchronous, pressed = 0
ALGORITHM_SELECTOR  in  1  raw pushbutton, asynchronous, pressed = 0
PROC_DONE  in  1  image_processing done, level or pulse
ALGORITHM  out  2  latched algorithm code to image_processing/display
PROC_START  out  1  one-cycle start pulse to image_processing
RAM_WREN  out  1  RAMProc write enable
ZOOM_REQUESTED  out  1  to zoom_controller
FRAME_VALID  out  1  RAM holds a complete frame; gates VGA colour
BUSY  out  1  pass in progress
ERROR  out  1  watchdog abort flag

Behaviour:
- Reset (RESET=0, async): state IDLE; all outputs 0; ALGORITHM=2'd0; debounced levels=1 (released); counters 0.
- Button path (each button): 2-FF synchronizer -> stability counter. Counter clears whenever synced level differs from debounced level. Debounced level takes synced level when counter reaches DEBOUNCE_CYCLES. Glitches shorter than DEBOUNCE_CYCLES are ignored. A press event is a one-cycle registered pulse on a debounced 1->0 transition. Release generates no event.
- Only the FSM updates all outputs; all outputs are registered.
- IDLE: SELECT event -> ALGORITHM = ALGORITHM+1 mod 4 (3 wraps to 0). RUN event -> ARM. Both events in the same cycle: SELECT wins, RUN is dropped.
- ARM (1 cycle): PROC_START=1, RAM_WREN=1, BUSY=1, FRAME_VALID=0, ZOOM_REQUESTED=0. PROC_DONE is ignored. Next state RUNNING.
- RUNNING: RAM_WREN=1, BUSY=1. PROC_DONE=1 -> FLUSH with flush counter=0.
- FLUSH: RAM_WREN=1, BUSY=1. The counter increments each cycle. After exactly FLUSH_CYCLES cycles in FLUSH -> SHOW.
- SHOW: RAM_WREN=0, BUSY=0, FRAME_VALID=1, ZOOM_REQUESTED=1.
  - RUN event -> ARM (re-run with current ALGORITHM).
  - SELECT event -> ALGORITHM increments, FRAME_VALID=0, ZOOM_REQUESTED=0, then IDLE.
  - Both events in the same cycle: SELECT wins.
- Events arriving in ARM/RUNNING/FLUSH are discarded (not queued). ALGORITHM is stable for the whole pass.
- Timing: press event at cycle E in IDLE -> PROC_START=1 and RAM_WREN=1 at E+1. PROC_DONE sampled high at cycle D -> RAM_WREN falls and FRAME_VALID rises at D+FLUSH_CYCLES+1.
- Async reset mid-pass returns to IDLE immediately. RAM_WREN drops asynchronously.

Optional Feature:
Macro: COPROCESSOR_SEQUENCER_WATCHDOG_EN.
- Defined: a watchdog counter clears on entry to RUNNING and increments each RUNNING cycle. When it reaches WATCHDOG_CYCLES without PROC_DONE:
  - state ERROR_HALT: RAM_WREN=0, BUSY=0, FRAME_VALID=0, ZOOM_REQUESTED=0, ERROR=1.
  - A RUN event clears ERROR and goes to IDLE without starting a pass. SELECT is ignored in ERROR_HALT.
- Undefined: RUNNING waits indefinitely; ERROR is constant 0; no watchdog counter is synthesized.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, FLUSH_CYCLES=2, WATCHDOG_CYCLES=50.
1. Reset: hold RESET=0 for 3 cycles -> all outputs 0, ALGORITHM=0. Release, no buttons for 20 cycles -> outputs unchanged.
2. Debounce: RUN low for 3 cycles then high -> no PROC_START. RUN low held for 10 cycles -> exactly one PROC_START pulse, RAM_WREN=1, BUSY=1.
3. Full pass: after start, PROC_DONE=1 at cycle D -> RAM_WREN=1 through D+2, then 0 at D+3 with FRAME_VALID=1, ZOOM_REQUESTED=1, BUSY=0.
4. Select: 5 SELECT presses in IDLE -> ALGORITHM 1,2,3,0,1. A SELECT press during RUNNING -> ALGORITHM unchanged. A SELECT press in SHOW -> ALGORITHM+1, FRAME_VALID=0, state IDLE.
5. Mid-pass reset: RESET=0 during RUNNING -> RAM_WREN=0 within the same cycle. After release, RUN press -> fresh PROC_START pulse.
6. Watchdog (macro defined): start, PROC_DONE held 0 -> ERROR=1, RAM_WREN=0 after 50 RUNNING cycles. RUN press -> ERROR=0, IDLE, no PROC_START. With the macro undefined the same stimulus gives ERROR=0 and RAM_WREN stays 1.
